// File: rtl/alu_muldiv_seq.sv
// Registered, handshaked MIPS ALU with iterative mul/div and HI/LO registers.
// Optional feature: define ALU_OVF_EN to add o_overflow for signed ADD/SUB.
module alu_muldiv_seq #(
    parameter int DATA_WIDTH = 8,
    parameter int MODE_WIDTH = 6,
    parameter int SHAMT_W    = $clog2(DATA_WIDTH)
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [DATA_WIDTH-1:0] i_A,
    input  logic [DATA_WIDTH-1:0] i_B,
    input  logic [MODE_WIDTH-1:0] i_mode,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_result,
    output logic [DATA_WIDTH-1:0] o_hi,
    output logic [DATA_WIDTH-1:0] o_lo
`ifdef ALU_OVF_EN
    ,
    output logic                  o_overflow
`endif
);

    localparam int W = DATA_WIDTH;

    localparam logic [MODE_WIDTH-1:0] F_ADD   = MODE_WIDTH'(6'b100000);
    localparam logic [MODE_WIDTH-1:0] F_ADDU  = MODE_WIDTH'(6'b100001);
    localparam logic [MODE_WIDTH-1:0] F_SUB   = MODE_WIDTH'(6'b100010);
    localparam logic [MODE_WIDTH-1:0] F_SUBU  = MODE_WIDTH'(6'b100011);
    localparam logic [MODE_WIDTH-1:0] F_AND   = MODE_WIDTH'(6'b100100);
    localparam logic [MODE_WIDTH-1:0] F_OR    = MODE_WIDTH'(6'b100101);
    localparam logic [MODE_WIDTH-1:0] F_XOR   = MODE_WIDTH'(6'b100110);
    localparam logic [MODE_WIDTH-1:0] F_NOR   = MODE_WIDTH'(6'b100111);
    localparam logic [MODE_WIDTH-1:0] F_SLT   = MODE_WIDTH'(6'b101000);
    localparam logic [MODE_WIDTH-1:0] F_SLTU  = MODE_WIDTH'(6'b101001);
    localparam logic [MODE_WIDTH-1:0] F_SLL   = MODE_WIDTH'(6'b000000);
    localparam logic [MODE_WIDTH-1:0] F_SRL   = MODE_WIDTH'(6'b000010);
    localparam logic [MODE_WIDTH-1:0] F_SRA   = MODE_WIDTH'(6'b000011);
    localparam logic [MODE_WIDTH-1:0] F_MFHI  = MODE_WIDTH'(6'b010000);
    localparam logic [MODE_WIDTH-1:0] F_MTHI  = MODE_WIDTH'(6'b010001);
    localparam logic [MODE_WIDTH-1:0] F_MFLO  = MODE_WIDTH'(6'b010010);
    localparam logic [MODE_WIDTH-1:0] F_MTLO  = MODE_WIDTH'(6'b010011);
    localparam logic [MODE_WIDTH-1:0] F_MULT  = MODE_WIDTH'(6'b011000);
    localparam logic [MODE_WIDTH-1:0] F_MULTU = MODE_WIDTH'(6'b011001);
    localparam logic [MODE_WIDTH-1:0] F_DIV   = MODE_WIDTH'(6'b011010);
    localparam logic [MODE_WIDTH-1:0] F_DIVU  = MODE_WIDTH'(6'b011011);

    localparam logic [SHAMT_W-1:0] CNT_LAST = SHAMT_W'(W - 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t             state;
    logic [SHAMT_W-1:0] cnt;
    logic [2*W-1:0]     acc;
    logic [W-1:0]       opnd;
    logic [W-1:0]       a_hold;
    logic [W-1:0]       hi;
    logic [W-1:0]       lo;
    logic [W-1:0]       result;
    logic               valid;
    logic               div_op;
    logic               neg_q;
    logic               neg_r;
    logic               dz;

    logic [W-1:0]       sum;
    logic [W-1:0]       diff;
    logic [SHAMT_W-1:0] shamt;
    logic [W-1:0]       alu_res;
    logic               is_long;
    logic               wr_hi;
    logic               wr_lo;

    assign sum   = i_A + i_B;
    assign diff  = i_A - i_B;
    assign shamt = i_B[SHAMT_W-1:0];

    always_comb begin
        alu_res = '1;
        is_long = 1'b0;
        wr_hi   = 1'b0;
        wr_lo   = 1'b0;
        unique case (i_mode)
            F_ADD, F_ADDU: alu_res = sum;
            F_SUB, F_SUBU: alu_res = diff;
            F_AND:  alu_res = i_A & i_B;
            F_OR:   alu_res = i_A | i_B;
            F_XOR:  alu_res = i_A ^ i_B;
            F_NOR:  alu_res = ~(i_A | i_B);
            F_SLT:  alu_res = W'($signed(i_A) < $signed(i_B));
            F_SLTU: alu_res = W'(i_A < i_B);
            F_SLL:  alu_res = i_A << shamt;
            F_SRL:  alu_res = i_A >> shamt;
            F_SRA:  alu_res = $unsigned($signed(i_A) >>> shamt);
            F_MFHI: alu_res = hi;
            F_MFLO: alu_res = lo;
            F_MTHI: begin
                alu_res = i_A;
                wr_hi   = 1'b1;
            end
            F_MTLO: begin
                alu_res = i_A;
                wr_lo   = 1'b1;
            end
            F_MULT, F_MULTU, F_DIV, F_DIVU: is_long = 1'b1;
            default: alu_res = '1;
        endcase
    end

    // Signed mul/div run on magnitudes; signs are fixed up on the last step.
    logic         op_signed;
    logic         op_div;
    logic         a_neg;
    logic         b_neg;
    logic [W-1:0] a_mag;
    logic [W-1:0] b_mag;

    assign op_signed = (i_mode == F_MULT) || (i_mode == F_DIV);
    assign op_div    = (i_mode == F_DIV) || (i_mode == F_DIVU);
    assign a_neg     = op_signed & i_A[W-1];
    assign b_neg     = op_signed & i_B[W-1];
    assign a_mag     = a_neg ? -i_A : i_A;
    assign b_mag     = b_neg ? -i_B : i_B;

    logic [W:0]     msum;
    logic [W:0]     rsh;
    logic [W:0]     rdiff;
    logic [2*W-1:0] mul_next;
    logic [2*W-1:0] div_next;
    logic [2*W-1:0] acc_next;
    logic [2*W-1:0] prod;
    logic [W-1:0]   quo;
    logic [W-1:0]   rem;
    logic [W-1:0]   fin_hi;
    logic [W-1:0]   fin_lo;

    // acc = {partial, multiplier} for mul, {remainder, dividend/quotient} for div
    assign msum     = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, opnd} : '0);
    assign mul_next = {msum, acc[W-1:1]};
    assign rsh      = {acc[2*W-1:W], acc[W-1]};
    assign rdiff    = rsh - {1'b0, opnd};
    assign div_next = rdiff[W] ? {rsh[W-1:0], acc[W-2:0], 1'b0}
                               : {rdiff[W-1:0], acc[W-2:0], 1'b1};
    assign acc_next = div_op ? div_next : mul_next;

    assign prod = neg_q ? -acc_next : acc_next;
    assign quo  = acc_next[W-1:0];
    assign rem  = acc_next[2*W-1:W];

    always_comb begin
        fin_hi = prod[2*W-1:W];
        fin_lo = prod[W-1:0];
        if (div_op) begin
            if (dz) begin
                fin_lo = '1;
                fin_hi = a_hold;
            end else begin
                fin_lo = neg_q ? -quo : quo;
                fin_hi = neg_r ? -rem : rem;
            end
        end
    end

`ifdef ALU_OVF_EN
    logic add_ovf;
    logic sub_ovf;
    logic ovf;

    assign add_ovf = (i_A[W-1] == i_B[W-1]) && (sum[W-1] != i_A[W-1]);
    assign sub_ovf = (i_A[W-1] != i_B[W-1]) && (diff[W-1] != i_A[W-1]);
`endif

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state  <= IDLE;
            cnt    <= '0;
            acc    <= '0;
            opnd   <= '0;
            a_hold <= '0;
            hi     <= '0;
            lo     <= '0;
            result <= '0;
            valid  <= 1'b0;
            div_op <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            dz     <= 1'b0;
`ifdef ALU_OVF_EN
            ovf    <= 1'b0;
`endif
        end else begin
            valid <= 1'b0;
`ifdef ALU_OVF_EN
            ovf   <= 1'b0;
`endif
            unique case (state)
                IDLE: begin
                    if (i_valid) begin
                        if (is_long) begin
                            state  <= BUSY;
                            cnt    <= '0;
                            div_op <= op_div;
                            neg_q  <= a_neg ^ b_neg;
                            neg_r  <= a_neg;
                            dz     <= op_div && (i_B == '0);
                            a_hold <= i_A;
                            opnd   <= op_div ? b_mag : a_mag;
                            acc    <= {{W{1'b0}}, op_div ? a_mag : b_mag};
                        end else begin
                            valid  <= 1'b1;
                            result <= alu_res;
                            if (wr_hi) hi <= i_A;
                            if (wr_lo) lo <= i_A;
`ifdef ALU_OVF_EN
                            ovf <= ((i_mode == F_ADD) && add_ovf) ||
                                   ((i_mode == F_SUB) && sub_ovf);
`endif
                        end
                    end
                end
                BUSY: begin
                    acc <= acc_next;
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        state  <= IDLE;
                        valid  <= 1'b1;
                        hi     <= fin_hi;
                        lo     <= fin_lo;
                        result <= fin_lo;
                    end
                end
            endcase
        end
    end

    assign o_ready  = (state == IDLE);
    assign o_valid  = valid;
    assign o_result = result;
    assign o_hi     = hi;
    assign o_lo     = lo;
`ifdef ALU_OVF_EN
    assign o_overflow = ovf;
`endif

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Scoreboard bench for alu_muldiv_seq at DATA_WIDTH=8.
// Expectations are pushed at issue; a negedge monitor pops on o_valid.
module tb_alu_muldiv_seq;

    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_ADDU  = 6'b100001;
    localparam logic [5:0] F_SUB   = 6'b100010;
    localparam logic [5:0] F_SUBU  = 6'b100011;
    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_XOR   = 6'b100110;
    localparam logic [5:0] F_NOR   = 6'b100111;
    localparam logic [5:0] F_SLT   = 6'b101000;
    localparam logic [5:0] F_SLTU  = 6'b101001;
    localparam logic [5:0] F_SLL   = 6'b000000;
    localparam logic [5:0] F_SRL   = 6'b000010;
    localparam logic [5:0] F_SRA   = 6'b000011;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_BAD   = 6'b111111;

    logic       clk = 1'b0;
    logic       rst;
    logic       vin;
    logic       rdy;
    logic [7:0] a;
    logic [7:0] b;
    logic [5:0] mode;
    logic       vout;
    logic [7:0] res;
    logic [7:0] hi;
    logic [7:0] lo;
`ifdef ALU_OVF_EN
    logic       ovf;
`endif

    alu_muldiv_seq #(.DATA_WIDTH(8), .MODE_WIDTH(6)) dut (
        .i_clk     (clk),
        .i_reset   (rst),
        .i_valid   (vin),
        .o_ready   (rdy),
        .i_A       (a),
        .i_B       (b),
        .i_mode    (mode),
        .o_valid   (vout),
        .o_result  (res),
        .o_hi      (hi),
        .o_lo      (lo)
`ifdef ALU_OVF_EN
        ,
        .o_overflow(ovf)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [7:0] r;
        logic [7:0] h;
        logic [7:0] l;
        logic       ov;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, want %h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && vout) begin
            if (sb.size() == 0) begin
                check("unexpected_valid", 32'(vout), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check({e.name, "_res"}, 32'(res), 32'(e.r));
                check({e.name, "_hi"}, 32'(hi), 32'(e.h));
                check({e.name, "_lo"}, 32'(lo), 32'(e.l));
`ifdef ALU_OVF_EN
                check({e.name, "_ovf"}, 32'(ovf), 32'(e.ov));
`endif
            end
        end
    end

    task automatic issue(input string name, input logic [5:0] m,
                         input logic [7:0] av, input logic [7:0] bv,
                         input logic [7:0] r, input logic [7:0] h,
                         input logic [7:0] l, input logic ov,
                         input bit push = 1'b1);
        int n;
        n = 0;
        while (!rdy && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 100) check({name, "_ready_timeout"}, 32'(rdy), 32'd1);
        vin  = 1'b1;
        mode = m;
        a    = av;
        b    = bv;
        if (push) sb.push_back('{name, r, h, l, ov});
        @(posedge clk);
        #1;
        vin = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1);
    end

    initial begin
        int lat;
        int low;
        rst  = 1'b1;
        vin  = 1'b1;
        mode = F_ADD;
        a    = 8'h7F;
        b    = 8'h01;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_valid", 32'(vout), 32'd0);
        check("rst_ready", 32'(rdy), 32'd1);
        check("rst_result", 32'(res), 32'd0);
        check("rst_hi", 32'(hi), 32'd0);
        check("rst_lo", 32'(lo), 32'd0);
        rst = 1'b0;
        vin = 1'b0;
        @(posedge clk);
        #1;

        issue("add_ovf", F_ADD, 8'h7F, 8'h01, 8'h80, 8'h00, 8'h00, 1'b1);
        issue("sub_b2b", F_SUB, 8'h00, 8'h01, 8'hFF, 8'h00, 8'h00, 1'b0);
        check("b2b_valid", 32'(vout), 32'd1);
        issue("addu", F_ADDU, 8'hFF, 8'h02, 8'h01, 8'h00, 8'h00, 1'b0);
        issue("subu", F_SUBU, 8'h05, 8'h07, 8'hFE, 8'h00, 8'h00, 1'b0);
        issue("and", F_AND, 8'hF0, 8'h3C, 8'h30, 8'h00, 8'h00, 1'b0);
        issue("or", F_OR, 8'hF0, 8'h3C, 8'hFC, 8'h00, 8'h00, 1'b0);
        issue("xor", F_XOR, 8'hF0, 8'h3C, 8'hCC, 8'h00, 8'h00, 1'b0);
        issue("nor", F_NOR, 8'hF0, 8'h3C, 8'h03, 8'h00, 8'h00, 1'b0);
        issue("sra", F_SRA, 8'h90, 8'h0A, 8'hE4, 8'h00, 8'h00, 1'b0);
        issue("srl", F_SRL, 8'h90, 8'h0A, 8'h24, 8'h00, 8'h00, 1'b0);
        issue("sll", F_SLL, 8'h01, 8'h09, 8'h02, 8'h00, 8'h00, 1'b0);
        issue("slt", F_SLT, 8'hFF, 8'h01, 8'h01, 8'h00, 8'h00, 1'b0);
        issue("sltu", F_SLTU, 8'hFF, 8'h01, 8'h00, 8'h00, 8'h00, 1'b0);
        issue("bad", F_BAD, 8'h12, 8'h34, 8'hFF, 8'h00, 8'h00, 1'b0);
        issue("mthi", F_MTHI, 8'h12, 8'h00, 8'h12, 8'h12, 8'h00, 1'b0);
        issue("mtlo", F_MTLO, 8'h34, 8'h00, 8'h34, 8'h12, 8'h34, 1'b0);
        issue("mfhi", F_MFHI, 8'h00, 8'h00, 8'h12, 8'h12, 8'h34, 1'b0);
        issue("mflo", F_MFLO, 8'h00, 8'h00, 8'h34, 8'h12, 8'h34, 1'b0);
        @(posedge clk);
        #1;

        // MULT timing; garbage requests during BUSY must be ignored
        issue("mult", F_MULT, 8'hFD, 8'h05, 8'hF1, 8'hFF, 8'hF1, 1'b0);
        vin  = 1'b1;
        mode = F_ADD;
        a    = 8'h00;
        b    = 8'h00;
        lat  = -1;
        low  = 0;
        for (int i = 0; i < 20; i++) begin
            if (vout) begin
                lat = i;
                break;
            end
            if (!rdy) low++;
            @(posedge clk);
            #1;
        end
        vin = 1'b0;
        check("mult_edges_to_valid", 32'(lat), 32'd8);
        check("mult_ready_low", 32'(low), 32'd8);
        check("mult_ready_at_valid", 32'(rdy), 32'd1);

        issue("multu", F_MULTU, 8'hFF, 8'hFF, 8'h01, 8'hFE, 8'h01, 1'b0);
        issue("divu", F_DIVU, 8'd200, 8'd7, 8'h1C, 8'h04, 8'h1C, 1'b0);
        issue("div_neg", F_DIV, 8'hF9, 8'h02, 8'hFD, 8'hFF, 8'hFD, 1'b0);
        issue("divu_zero", F_DIVU, 8'h2A, 8'h00, 8'hFF, 8'h2A, 8'hFF, 1'b0);
        issue("div_minneg", F_DIV, 8'h80, 8'hFF, 8'h80, 8'h00, 8'h80, 1'b0);
        issue("mult_minneg", F_MULT, 8'h80, 8'h80, 8'h00, 8'h40, 8'h00, 1'b0);
        issue("bad_keep", F_BAD, 8'h00, 8'h00, 8'hFF, 8'h40, 8'h00, 1'b0);

        issue("mthi2", F_MTHI, 8'h12, 8'h00, 8'h12, 8'h12, 8'h00, 1'b0);
        issue("mtlo2", F_MTLO, 8'h34, 8'h00, 8'h34, 8'h12, 8'h34, 1'b0);
        issue("mult_abort", F_MULT, 8'h03, 8'h04, 8'h00, 8'h00, 8'h00, 1'b0,
              1'b0);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (12) begin
            @(posedge clk);
            #1;
        end
        check("abort_hi", 32'(hi), 32'd0);
        check("abort_lo", 32'(lo), 32'd0);
        check("abort_ready", 32'(rdy), 32'd1);
        issue("mfhi_after", F_MFHI, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);

        repeat (4) @(posedge clk);
        #1;
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
